// File: rtl/escritura_rtc_pkg.sv
// Shared definitions for the RTC bus write block (escritura_rtc) and the
// companion RTC read block: FSM state encoding, default bus timing and
// small helpers. The optional BCD check (ESCRITURA_RTC_BCD_CHECK_EN) uses bcd_ok.
package escritura_rtc_pkg;

  localparam int DEF_T_SETUP = 2;
  localparam int DEF_T_PULSE = 5;
  localparam int DEF_T_HOLD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ADDR_SETUP = 3'd1,
    ST_ADDR_WR    = 3'd2,
    ST_ADDR_HOLD  = 3'd3,
    ST_DATA_SETUP = 3'd4,
    ST_DATA_WR    = 3'd5,
    ST_DATA_HOLD  = 3'd6,
    ST_DONE       = 3'd7
  } rtc_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The phase counter only ever holds (phase length - 1), so clog2 of the
  // longest phase is enough; keep at least one bit for all-ones timing.
  function automatic int cnt_width(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/escritura_rtc_timer.sv
// Loadable down-counter with a zero flag; times every bus phase of the
// RTC write FSM. Load has priority over counting; it stops at zero.
module escritura_rtc_timer
  import escritura_rtc_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count_en,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Reload on each phase entry, otherwise count down toward zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count_en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/escritura_rtc.sv
// RTC multiplexed-bus write sequencer: address phase then data phase, each
// with setup / wr_n pulse / hold timing, followed by a one-cycle done.
// Optional macro ESCRITURA_RTC_BCD_CHECK_EN rejects non-BCD dato with err.
// All bus strobes and status outputs are registered (decoded from next state).
module escritura_rtc
  import escritura_rtc_pkg::*;
#(
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_PULSE = DEF_T_PULSE,
  parameter int T_HOLD  = DEF_T_HOLD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] dato,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       ad_n,
  output logic [7:0] ad_out,
  output logic       ad_oe
);

  localparam int T_MAX = max3(T_SETUP, T_PULSE, T_HOLD);
  localparam int CNT_W = cnt_width(T_MAX);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);

  rtc_state_t       state;
  rtc_state_t       next_state;
  logic [7:0]       addr_q;
  logic [7:0]       dato_q;
  logic [7:0]       addr_nx;
  logic [7:0]       dato_nx;
  logic             accept;
  logic             start_ok;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_en;
  logic             tmr_zero;

  logic             busy_d;
  logic             done_d;
  logic             cs_n_d;
  logic             wr_n_d;
  logic             ad_n_d;
  logic             ad_oe_d;
  logic [7:0]       ad_out_d;

  escritura_rtc_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .count_en (tmr_en),
    .zero     (tmr_zero)
  );

`ifdef ESCRITURA_RTC_BCD_CHECK_EN
  assign start_ok = bcd_ok(dato);

  // A rejected request in IDLE produces a single-cycle err and no bus activity
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else begin
      err <= (state == ST_IDLE) && start && !start_ok;
    end
  end
`else
  assign start_ok = 1'b1;
  assign err      = 1'b0;
`endif

  assign rd_n = 1'b1;

  // Next-state and phase-timer control; each phase reloads the timer on entry
  always_comb begin
    next_state   = state;
    accept       = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && start_ok) begin
          accept       = 1'b1;
          next_state   = ST_ADDR_SETUP;
          tmr_load     = 1'b1;
          tmr_load_val = LD_SETUP;
        end
      end
      ST_ADDR_SETUP: begin
        if (tmr_zero) begin
          next_state   = ST_ADDR_WR;
          tmr_load     = 1'b1;
          tmr_load_val = LD_PULSE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_ADDR_WR: begin
        if (tmr_zero) begin
          next_state   = ST_ADDR_HOLD;
          tmr_load     = 1'b1;
          tmr_load_val = LD_HOLD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_ADDR_HOLD: begin
        if (tmr_zero) begin
          next_state   = ST_DATA_SETUP;
          tmr_load     = 1'b1;
          tmr_load_val = LD_SETUP;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DATA_SETUP: begin
        if (tmr_zero) begin
          next_state   = ST_DATA_WR;
          tmr_load     = 1'b1;
          tmr_load_val = LD_PULSE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DATA_WR: begin
        if (tmr_zero) begin
          next_state   = ST_DATA_HOLD;
          tmr_load     = 1'b1;
          tmr_load_val = LD_HOLD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DATA_HOLD: begin
        if (tmr_zero) begin
          next_state = ST_DONE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Captured operands as they will be after this edge, so the first bus
  // cycle already shows the new address
  always_comb begin
    addr_nx = accept ? addr : addr_q;
    dato_nx = accept ? dato : dato_q;
  end

  // Output values for the state about to be entered; registered below
  always_comb begin
    busy_d   = (next_state != ST_IDLE);
    done_d   = (next_state == ST_DONE);
    cs_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    ad_n_d   = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = '0;
    case (next_state)
      ST_ADDR_SETUP, ST_ADDR_WR, ST_ADDR_HOLD: begin
        cs_n_d   = 1'b0;
        ad_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_nx;
        wr_n_d   = (next_state != ST_ADDR_WR);
      end
      ST_DATA_SETUP, ST_DATA_WR, ST_DATA_HOLD: begin
        cs_n_d   = 1'b0;
        ad_n_d   = 1'b1;
        ad_oe_d  = 1'b1;
        ad_out_d = dato_nx;
        wr_n_d   = (next_state != ST_DATA_WR);
      end
      default: begin
        cs_n_d = 1'b1;
      end
    endcase
  end

  // State and operand capture; reset abandons any write in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      dato_q <= '0;
    end else begin
      state  <= next_state;
      addr_q <= addr_nx;
      dato_q <= dato_nx;
    end
  end

  // Registered bus strobes and status so the RTC never sees decode glitches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      cs_n   <= 1'b1;
      wr_n   <= 1'b1;
      ad_n   <= 1'b1;
      ad_oe  <= 1'b0;
      ad_out <= '0;
    end else begin
      busy   <= busy_d;
      done   <= done_d;
      cs_n   <= cs_n_d;
      wr_n   <= wr_n_d;
      ad_n   <= ad_n_d;
      ad_oe  <= ad_oe_d;
      ad_out <= ad_out_d;
    end
  end

endmodule

// File: tb/tb_escritura_rtc.sv
// Self-checking bench for escritura_rtc: reset state, a directed vector
// table for the default-timing write, input-change and ignored-start cases,
// mid-write reset, optional BCD rejection, randomized traffic against a
// cycle-count reference model, and a fast-timing instance with held start.
`timescale 1ns/1ps
module tb_escritura_rtc;
  import escritura_rtc_pkg::*;

  localparam int TS = DEF_T_SETUP;
  localparam int TP = DEF_T_PULSE;
  localparam int TH = DEF_T_HOLD;
  localparam int LEN = TS + TP + TH;

`ifdef ESCRITURA_RTC_BCD_CHECK_EN
  localparam bit BCD_CHECK = 1'b1;
`else
  localparam bit BCD_CHECK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] dato = 8'h00;
  logic       busy, done, err, cs_n, wr_n, rd_n, ad_n, ad_oe;
  logic [7:0] ad_out;

  logic       start_f = 1'b0;
  logic [7:0] addr_f = 8'h00;
  logic [7:0] dato_f = 8'h00;
  logic       busy_f, done_f, err_f, cs_n_f, wr_n_f, rd_n_f, ad_n_f, ad_oe_f;
  logic [7:0] ad_out_f;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         k;
    logic       cs_n;
    logic       wr_n;
    logic       ad_n;
    logic       done;
    logic [7:0] ad_out;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  escritura_rtc dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .addr   (addr),
    .dato   (dato),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .cs_n   (cs_n),
    .wr_n   (wr_n),
    .rd_n   (rd_n),
    .ad_n   (ad_n),
    .ad_out (ad_out),
    .ad_oe  (ad_oe)
  );

  escritura_rtc #(
    .T_SETUP (1),
    .T_PULSE (1),
    .T_HOLD  (1)
  ) dut_fast (
    .clk    (clk),
    .reset  (reset),
    .start  (start_f),
    .addr   (addr_f),
    .dato   (dato_f),
    .busy   (busy_f),
    .done   (done_f),
    .err    (err_f),
    .cs_n   (cs_n_f),
    .wr_n   (wr_n_f),
    .rd_n   (rd_n_f),
    .ad_n   (ad_n_f),
    .ad_out (ad_out_f),
    .ad_oe  (ad_oe_f)
  );

  // Observed outputs packed as {busy,done,err,cs_n,wr_n,rd_n,ad_n,ad_oe,ad_out}
  function automatic logic [15:0] obsMain();
    return {busy, done, err, cs_n, wr_n, rd_n, ad_n, ad_oe, ad_out};
  endfunction

  function automatic logic [15:0] obsFast();
    return {busy_f, done_f, err_f, cs_n_f, wr_n_f, rd_n_f, ad_n_f, ad_oe_f, ad_out_f};
  endfunction

  function automatic bit bcdValid(input logic [7:0] d);
    return !BCD_CHECK || ((d[7:4] < 4'd10) && (d[3:0] < 4'd10));
  endfunction

  // Reference: outputs in cycle k after the accepting edge (k=0 means idle)
  function automatic logic [15:0] expOut(input int k, input logic [7:0] a, input logic [7:0] d,
                                         input int ts, input int tp, input int th, input logic e);
    int         len;
    int         off;
    logic       b, dn, cs, wr, adn, oe;
    logic [7:0] bus;
    len = ts + tp + th;
    b = 1'b0; dn = 1'b0; cs = 1'b1; wr = 1'b1; adn = 1'b1; oe = 1'b0; bus = 8'h00;
    if (k >= 1 && k <= 2 * len) begin
      b   = 1'b1;
      cs  = 1'b0;
      oe  = 1'b1;
      off = (k - 1) % len;
      adn = (k > len);
      bus = (k > len) ? d : a;
      wr  = !(off >= ts && off < ts + tp);
    end else if (k == 2 * len + 1) begin
      b  = 1'b1;
      dn = 1'b1;
    end
    return {b, dn, e, cs, wr, 1'b1, adn, oe, bus};
  endfunction

  task automatic applyStimulus(input logic s, input logic [7:0] a, input logic [7:0] d);
    start = s;
    addr  = a;
    dato  = d;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete write on the default-timing DUT, every cycle against the model
  task automatic runTxn(input string name, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    applyStimulus(1'b1, a, d);
    for (int k = 1; k <= 2 * LEN + 2; k++) begin
      @(negedge clk);
      checkOutput(name, obsMain(), expOut(k, a, d, TS, TP, TH, 1'b0));
      if (k == 1) applyStimulus(1'b0, ~a, ~d);
    end
  endtask

  // Cycle-level model run: random or held start, drained to idle at the end
  task automatic runModel(input bit fast, input int ncycles, input bit heldStart);
    int          ts, tp, th, len, mk, lastDone, periods;
    logic [7:0]  ma, md, a, d;
    logic        me, s;
    logic [15:0] act;
    ts = fast ? 1 : TS;
    tp = fast ? 1 : TP;
    th = fast ? 1 : TH;
    len = ts + tp + th;
    mk = 0; me = 1'b0; ma = 8'h00; md = 8'h00; lastDone = -1; periods = 0;
    for (int c = 0; c < ncycles; c++) begin
      @(negedge clk);
      act = fast ? obsFast() : obsMain();
      checkOutput(fast ? "model_fast" : "model_rand", act, expOut(mk, ma, md, ts, tp, th, me));
      if (fast && heldStart && act[14]) begin
        if (lastDone >= 0) begin
          checkOutput("done_period", 16'(c - lastDone), 16'(2 * len + 2));
          periods++;
        end
        lastDone = c;
      end
      s = heldStart ? 1'b1 : ($urandom_range(0, 3) == 0);
      if (c >= ncycles - (2 * len + 3)) s = 1'b0;
      a = 8'($urandom);
      d = ($urandom_range(0, 4) == 0) ? 8'($urandom)
                                      : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if (fast) begin
        start_f = s; addr_f = a; dato_f = fast && heldStart ? 8'h12 : d;
        if (heldStart) d = 8'h12;
      end else begin
        applyStimulus(s, a, d);
      end
      me = 1'b0;
      if (mk == 0) begin
        if (s) begin
          if (bcdValid(d)) begin
            mk = 1; ma = a; md = d;
          end else begin
            me = 1'b1;
          end
        end
      end else if (mk == 2 * len + 1) begin
        mk = 0;
      end else begin
        mk++;
      end
    end
    if (fast && heldStart) checkOutput("done_periods_seen", 16'(periods >= 3), 16'd1);
  endtask

  initial begin
    int csLow;
    int doneCnt;
    int activity;

    vecs[0]  = '{1,  1'b0, 1'b1, 1'b0, 1'b0, 8'h21};
    vecs[1]  = '{2,  1'b0, 1'b1, 1'b0, 1'b0, 8'h21};
    vecs[2]  = '{3,  1'b0, 1'b0, 1'b0, 1'b0, 8'h21};
    vecs[3]  = '{7,  1'b0, 1'b0, 1'b0, 1'b0, 8'h21};
    vecs[4]  = '{8,  1'b0, 1'b1, 1'b0, 1'b0, 8'h21};
    vecs[5]  = '{9,  1'b0, 1'b1, 1'b0, 1'b0, 8'h21};
    vecs[6]  = '{10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h45};
    vecs[7]  = '{12, 1'b0, 1'b0, 1'b1, 1'b0, 8'h45};
    vecs[8]  = '{16, 1'b0, 1'b0, 1'b1, 1'b0, 8'h45};
    vecs[9]  = '{17, 1'b0, 1'b1, 1'b1, 1'b0, 8'h45};
    vecs[10] = '{18, 1'b0, 1'b1, 1'b1, 1'b0, 8'h45};
    vecs[11] = '{19, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00};
    vecs[12] = '{20, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};

    // Reset state, with a request pending that must be ignored
    applyStimulus(1'b1, 8'h33, 8'h44);
    repeat (3) @(negedge clk);
    checkOutput("reset_idle", obsMain(), expOut(0, 8'h00, 8'h00, TS, TP, TH, 1'b0));
    checkOutput("reset_idle_fast", obsFast(), expOut(0, 8'h00, 8'h00, 1, 1, 1, 1'b0));
    applyStimulus(1'b0, 8'h00, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle_after_reset", obsMain(), expOut(0, 8'h00, 8'h00, TS, TP, TH, 1'b0));

    // Directed write 0x21/0x45: inputs change mid-write, extra start at cycle 8
    $display("[TB] directed write");
    csLow = 0;
    doneCnt = 0;
    @(negedge clk);
    applyStimulus(1'b1, 8'h21, 8'h45);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      foreach (vecs[i]) begin
        if (vecs[i].k == k) begin
          checkOutput($sformatf("vec_k%0d", k), {4'h0, cs_n, wr_n, ad_n, done, ad_out},
                      {4'h0, vecs[i].cs_n, vecs[i].wr_n, vecs[i].ad_n, vecs[i].done, vecs[i].ad_out});
        end
      end
      checkOutput($sformatf("busy_k%0d", k), {15'h0, busy}, {15'h0, (k <= 19)});
      if (!cs_n) csLow++;
      if (done) doneCnt++;
      if (k == 1) applyStimulus(1'b0, 8'h21, 8'h45);
      if (k == 3) applyStimulus(1'b0, 8'hFF, 8'hFF);
      if (k == 8) applyStimulus(1'b1, 8'hFF, 8'hFF);
      if (k == 9) applyStimulus(1'b0, 8'hFF, 8'hFF);
    end
    checkOutput("cs_low_cycles", 16'(csLow), 16'd18);
    checkOutput("single_done", 16'(doneCnt), 16'd1);

    // Reset asserted during the data wr_n pulse
    $display("[TB] reset during write");
    @(negedge clk);
    applyStimulus(1'b1, 8'h5A, 8'h12);
    @(negedge clk);
    applyStimulus(1'b0, 8'h5A, 8'h12);
    repeat (12) @(negedge clk);
    checkOutput("pre_reset_data_wr", {12'h0, wr_n, ad_n, cs_n, busy}, {12'h0, 4'b0101});
    #2 reset = 1'b0;
    #1;
    checkOutput("reset_mid_write", obsMain(), expOut(0, 8'h00, 8'h00, TS, TP, TH, 1'b0));
    @(negedge clk);
    reset = 1'b1;
    activity = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!cs_n || done || busy) activity++;
    end
    checkOutput("no_resume", 16'(activity), 16'd0);

    // Non-BCD request: rejected when checking is built in, written otherwise
    $display("[TB] bcd handling");
`ifdef ESCRITURA_RTC_BCD_CHECK_EN
    @(negedge clk);
    applyStimulus(1'b1, 8'h10, 8'h3A);
    @(negedge clk);
    applyStimulus(1'b0, 8'h10, 8'h3A);
    checkOutput("bcd_reject", obsMain(), expOut(0, 8'h00, 8'h00, TS, TP, TH, 1'b1));
    @(negedge clk);
    checkOutput("bcd_err_pulse", obsMain(), expOut(0, 8'h00, 8'h00, TS, TP, TH, 1'b0));
`else
    runTxn("unchecked_3a", 8'h10, 8'h3A);
`endif
    runTxn("bcd_59", 8'h11, 8'h59);

    // Randomized traffic on the default DUT
    $display("[TB] random traffic");
    runModel(1'b0, 700, 1'b0);

    // Minimum timing with start held high: a write every 8 cycles
    $display("[TB] fast back-to-back");
    runModel(1'b1, 60, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
